// File: rtl/fu_exec_sequencer_pkg.sv
// Shared constants for the per-FU execution sequencer: FSM state encoding,
// configuration register addresses and run status codes.
package fu_exec_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_CLEAR = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam logic [1:0] CFG_DELAY   = 2'd0;
  localparam logic [1:0] CFG_FORK    = 2'd1;
  localparam logic [1:0] CFG_TARGET  = 2'd2;
  localparam logic [1:0] CFG_TIMEOUT = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;

endpackage

// File: rtl/fu_exec_sequencer_timer.sv
// Saturating stall counter. The hit output flags that this cycle's increment
// brings the count up to a non-zero limit, so the owner can leave RUN on the
// very cycle the limit is reached.
module exec_stall_timer #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic [TO_W-1:0] limit,
  output logic            hit
);

  logic [TO_W-1:0] count_r;
  logic [TO_W-1:0] count_inc_s;

  // Saturating increment value and limit compare on the incremented count.
  always_comb begin
    count_inc_s = count_r;
    if (count_r == {TO_W{1'b1}}) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + {{(TO_W-1){1'b0}}, 1'b1};
    end
    hit = inc && (limit != {TO_W{1'b0}}) && (count_inc_s == limit);
  end

  // Stall count register: clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {TO_W{1'b0}};
    end else if (clr) begin
      count_r <= {TO_W{1'b0}};
    end else if (inc) begin
      count_r <= count_inc_s;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/fu_exec_sequencer.sv
// Per-FU execution sequencer: holds FU configuration, clears the FU before a
// run, then counts output tokens until target, stall timeout or abort.
module fu_exec_sequencer
  import fu_exec_sequencer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TO_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_data_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             fu_out_v_i,
  output logic             fu_clr_o,
  output logic             fu_initial_valid_o,
  output logic [15:0]      fu_delay_value_o,
  output logic [5:0]       fu_fork_mask_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] token_count_o
);

  state_t           state_r, state_nxt_s;
  logic             initial_valid_r;
  logic [15:0]      delay_r;
  logic [5:0]       fork_r;
  logic [CNT_W-1:0] target_r;
  logic [TO_W-1:0]  limit_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [1:0]       status_r, status_nxt_s;
  logic             busy_r, done_r, clr_r;
  logic             start_s, target_hit_s, timer_clr_s, timer_inc_s, timer_hit_s;
  logic             run_s;

  assign run_s       = (state_r == S_RUN);
  assign timer_clr_s = start_s || (run_s && fu_out_v_i);
  assign timer_inc_s = run_s && !fu_out_v_i;

  exec_stall_timer #(.TO_W(TO_W)) u_timer (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (timer_clr_s),
    .inc   (timer_inc_s),
    .limit (limit_r),
    .hit   (timer_hit_s)
  );

  // Next-state, token count and status decode; end conditions in priority order.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    status_nxt_s = status_r;
    start_s      = 1'b0;
    target_hit_s = fu_out_v_i && (count_r != {CNT_W{1'b1}}) &&
                   ((count_r + {{(CNT_W-1){1'b0}}, 1'b1}) == target_r);
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          state_nxt_s  = S_CLEAR;
          count_nxt_s  = {CNT_W{1'b0}};
          status_nxt_s = ST_OK;
          start_s      = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: state_nxt_s = S_RUN;
      S_RUN: begin
        if (fu_out_v_i && (count_r != {CNT_W{1'b1}})) begin
          count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          count_nxt_s = count_r;
        end
        if (abort_i) begin
          state_nxt_s  = S_DONE;
          status_nxt_s = ST_ABORT;
        end else if (target_r == {CNT_W{1'b0}} || target_hit_s) begin
          state_nxt_s  = S_DONE;
          status_nxt_s = ST_OK;
        end else if (timer_hit_s) begin
          state_nxt_s  = S_DONE;
          status_nxt_s = ST_TIMEOUT;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM, counter, status and state-decoded outputs, all registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= S_IDLE;
      count_r  <= {CNT_W{1'b0}};
      status_r <= ST_OK;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      clr_r    <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      count_r  <= count_nxt_s;
      status_r <= status_nxt_s;
      busy_r   <= (state_nxt_s != S_IDLE);
      done_r   <= (state_nxt_s == S_DONE);
      clr_r    <= (state_nxt_s != S_RUN);
    end
  end

  // Configuration registers; writes only land while idle so the FU sees
  // stable configuration for the whole CLEAR/RUN window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      initial_valid_r <= 1'b0;
      delay_r         <= 16'd0;
      fork_r          <= 6'd0;
      target_r        <= {CNT_W{1'b0}};
      limit_r         <= {TO_W{1'b0}};
    end else if (cfg_we_i && (state_r == S_IDLE)) begin
      case (cfg_addr_i)
        CFG_DELAY: begin
          initial_valid_r <= cfg_data_i[16];
          delay_r         <= cfg_data_i[15:0];
        end
        CFG_FORK:    fork_r   <= cfg_data_i[5:0];
        CFG_TARGET:  target_r <= cfg_data_i[CNT_W-1:0];
        CFG_TIMEOUT: limit_r  <= cfg_data_i[TO_W-1:0];
        default:     fork_r   <= fork_r;
      endcase
    end else begin
      fork_r <= fork_r;
    end
  end

  assign fu_clr_o           = clr_r;
  assign fu_initial_valid_o = initial_valid_r;
  assign fu_delay_value_o   = delay_r;
  assign fu_fork_mask_o     = fork_r;
  assign busy_o             = busy_r;
  assign done_o             = done_r;
  assign status_o           = status_r;
  assign token_count_o      = count_r;

endmodule

// File: tb/tb_fu_exec_sequencer.sv
// Directed bench for fu_exec_sequencer; cycle numbers in the comments count
// from the cycle in which start_i is sampled (cycle 0).
module tb_fu_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fu_out_v = 1'b0;
  logic        fu_clr, fu_iv, busy, done;
  logic [15:0] fu_delay;
  logic [5:0]  fu_fork;
  logic [1:0]  status;
  logic [31:0] token_count;

  int checks = 0;
  int errors = 0;

  fu_exec_sequencer dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cfg_we_i           (cfg_we),
    .cfg_addr_i         (cfg_addr),
    .cfg_data_i         (cfg_data),
    .start_i            (start),
    .abort_i            (abort),
    .fu_out_v_i         (fu_out_v),
    .fu_clr_o           (fu_clr),
    .fu_initial_valid_o (fu_iv),
    .fu_delay_value_o   (fu_delay),
    .fu_fork_mask_o     (fu_fork),
    .busy_o             (busy),
    .done_o             (done),
    .status_o           (status),
    .token_count_o      (token_count)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_clr", {63'd0, fu_clr}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_status", {62'd0, status}, 64'd0);
    check("rst_count", {32'd0, token_count}, 64'd0);
    rst = 1'b0;
    step();

    // Reset mid-RUN after 3 tokens
    cfg_write(2'd1, 32'h0000_0015);
    cfg_write(2'd2, 32'd10);
    start = 1'b1; step(); start = 1'b0;            // cycle 1
    step();                                        // cycle 2
    fu_out_v = 1'b1; step(); step(); step();       // tokens in 2,3,4
    fu_out_v = 1'b0;
    check("pre_rst_count", {32'd0, token_count}, 64'd3);
    #2 rst = 1'b1; #1;
    check("mid_rst_clr", {63'd0, fu_clr}, 64'd1);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_count", {32'd0, token_count}, 64'd0);
    check("mid_rst_fork", {58'd0, fu_fork}, 64'd0);
    step(); rst = 1'b0; step();

    // Config + 4 tokens spaced 2 cycles apart
    cfg_write(2'd0, 32'h0001_0005);
    cfg_write(2'd1, 32'h0000_0021);
    cfg_write(2'd2, 32'd4);
    start = 1'b1; step(); start = 1'b0;            // cycle 1
    check("c1_busy", {63'd0, busy}, 64'd1);
    check("c1_clr", {63'd0, fu_clr}, 64'd1);
    step();                                        // cycle 2
    check("c2_clr", {63'd0, fu_clr}, 64'd0);
    check("cfg_iv", {63'd0, fu_iv}, 64'd1);
    check("cfg_delay", {48'd0, fu_delay}, 64'd5);
    check("cfg_fork", {58'd0, fu_fork}, 64'h21);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("pre_final_done", {63'd0, done}, 64'd0);
      fu_out_v = 1'b1; step();
      fu_out_v = 1'b0; if (i < 3) step();
    end                                            // now cycle 9
    check("tgt_done", {63'd0, done}, 64'd1);
    check("tgt_status", {62'd0, status}, 64'd0);
    check("tgt_count", {32'd0, token_count}, 64'd4);
    step();                                        // cycle 10
    check("tgt_done_pulse", {63'd0, done}, 64'd0);
    check("tgt_idle", {63'd0, busy}, 64'd0);

    // Timeout 3, target 10, no tokens
    cfg_write(2'd2, 32'd10);
    cfg_write(2'd3, 32'd3);
    start = 1'b1; step(); start = 1'b0;            // cycle 1
    step(); step(); step();                        // cycle 4
    check("to_early_done", {63'd0, done}, 64'd0);
    step();                                        // cycle 5
    check("to_done", {63'd0, done}, 64'd1);
    check("to_status", {62'd0, status}, 64'd1);
    check("to_count", {32'd0, token_count}, 64'd0);
    step();

    // Token exactly on the expiry cycle restarts the stall counter
    start = 1'b1; step(); start = 1'b0;            // cycle 1
    step(); step(); step();                        // cycle 4
    fu_out_v = 1'b1; step(); fu_out_v = 1'b0;      // cycle 5
    check("exp_tok_done", {63'd0, done}, 64'd0);
    check("exp_tok_count", {32'd0, token_count}, 64'd1);
    step(); step();                                // cycle 7
    check("exp_tok_busy", {63'd0, busy}, 64'd1);
    step();                                        // cycle 8
    check("restart_to_done", {63'd0, done}, 64'd1);
    check("restart_to_status", {62'd0, status}, 64'd1);
    step();

    // Abort together with the final token
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd3, 32'd0);
    start = 1'b1; step(); start = 1'b0;            // cycle 1
    step();                                        // cycle 2
    fu_out_v = 1'b1; step();                       // cycle 3
    abort = 1'b1; step();                          // cycle 4
    fu_out_v = 1'b0; abort = 1'b0;
    check("abort_done", {63'd0, done}, 64'd1);
    check("abort_status", {62'd0, status}, 64'd2);
    check("abort_count", {32'd0, token_count}, 64'd2);
    step();

    // Config writes during RUN are dropped
    start = 1'b1; step(); start = 1'b0;            // cycle 1
    step();                                        // cycle 2
    cfg_write(2'd1, 32'h0000_003F);                // cycle 3
    cfg_write(2'd0, 32'h0000_1234);                // cycle 4
    check("run_wr_fork", {58'd0, fu_fork}, 64'h21);
    check("run_wr_delay", {48'd0, fu_delay}, 64'd5);
    check("run_wr_iv", {63'd0, fu_iv}, 64'd1);
    abort = 1'b1; step(); abort = 1'b0;            // cycle 5: DONE
    check("run_wr_abort", {62'd0, status}, 64'd2);
    step();

    // Target 0 written in the same cycle as start
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 32'd0; start = 1'b1;
    step();                                        // cycle 1
    cfg_we = 1'b0; start = 1'b0;
    step();                                        // cycle 2
    check("t0_run_done", {63'd0, done}, 64'd0);
    check("t0_run_clr", {63'd0, fu_clr}, 64'd0);
    step();                                        // cycle 3
    check("t0_done", {63'd0, done}, 64'd1);
    check("t0_status", {62'd0, status}, 64'd0);
    check("t0_count", {32'd0, token_count}, 64'd0);
    step();
    check("t0_idle", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_exec_sequencer.md
# fu_exec_sequencer

Per-FU execution sequencer for the CGRA fabric. It holds the FU control configuration (initial valid, delay value, fork mask) and clears the FU control logic before each run. It then releases the FU and counts output tokens until a programmed target is reached, a stall timeout fires, or software aborts. It sits between the configuration bus and one FU control instance, and reports busy, done and status to the array controller.

## Interface
Parameters:
- CNT_W, 32, width of the token target and token counter
- TO_W, 16, width of the stall-timeout limit and stall counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- cfg_we_i  in  1  configuration write strobe
- cfg_addr_i  in  2  0: {initial_valid[16], delay_value[15:0]}; 1: fork_mask[5:0]; 2: token target; 3: timeout limit
- cfg_data_i  in  32  write data; upper bits ignored per field
- start_i  in  1  start a run (accepted only in IDLE)
- abort_i  in  1  abort the current run
- fu_out_v_i  in  1  FU output-valid token (one token per high cycle)
- fu_clr_o  out  1  synchronous clear to the FU control
- fu_initial_valid_o  out  1  configuration to the FU
- fu_delay_value_o  out  16  configuration to the FU
- fu_fork_mask_o  out  6  configuration to the FU
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle pulse at run end
- status_o  out  2  0 ok, 1 timeout, 2 aborted; valid from done_o, held until next start
- token_count_o  out  CNT_W  tokens seen in the current or last run

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - Config writes accepted; writes in other states are dropped silently.
  - start_i moves to CLEAR.
  - Starting a run zeroes token_count and the stall counter.
- CLEAR: lasts exactly one cycle, then RUN.
- RUN:
  - Each fu_out_v_i cycle increments token_count and zeroes the stall counter.
  - Each cycle without a token increments the stall counter.
  - End conditions are evaluated in this priority order:
    1. abort_i: go to DONE, status 2.
    2. A token that makes token_count equal the target: go to DONE, status 0.
    3. Timeout limit is non-zero and the stall counter reaches the limit: go to DONE, status 1.
  - A token in the same cycle as timeout expiry counts as a token; the run does not time out.
- Target 0: RUN lasts one cycle and then DONE with status 0, unless abort_i is also high (status 2). No tokens are required.
- DONE: done_o is high for one cycle, then IDLE.
- abort_i in IDLE, CLEAR or DONE is ignored.
- fu_clr_o is high whenever the state is not RUN. The FU is held cleared while idle, and its initial_load happens on the first RUN cycle.
- Config outputs are driven directly from registers and are stable throughout CLEAR and RUN.
- Counters saturate at all-ones and never wrap. Saturated token_count can never equal a larger target. Arithmetic is unsigned.

## Timing
- Reset values:
  - State IDLE; fu_clr_o=1.
  - All config registers 0.
  - busy_o=0, done_o=0, status_o=0, token_count_o=0.
- Reset asserted mid-run returns the block to IDLE immediately (asynchronously), with the reset values above.
- All outputs are registered or decoded from state only (Moore); there are no combinational input-to-output paths.
- Run sequence, with start_i high in cycle 0 while in IDLE:
  - Cycle 1: CLEAR, fu_clr_o=1, busy_o=1.
  - Cycle 2: RUN, fu_clr_o=0.
  - Final token sampled in cycle k: DONE in cycle k+1, with done_o=1 and status_o valid.
  - Cycle k+2: IDLE; start_i is accepted again in that cycle.
- A config write in cycle 0 together with start_i takes effect; the written value is visible from cycle 1.
- Timeout: with limit L and no tokens from cycle 2 onward, DONE occurs in cycle L+2.

## Structure
- Package fu_exec_sequencer_pkg holds:
  - The state enum.
  - Config address constants: CFG_DELAY=0, CFG_FORK=1, CFG_TARGET=2, CFG_TIMEOUT=3.
  - Status codes: ST_OK, ST_TIMEOUT, ST_ABORT.
- Sub-module exec_stall_timer: TO_W-wide saturating counter with clear, increment and limit-compare output.
- The FSM, config registers and token counter stay in the top module.

## Test plan
- Reset mid-RUN after 3 tokens: immediately state IDLE, fu_clr_o=1, token_count_o=0, config registers 0.
- Write delay=5, initial_valid=1, fork mask 0x21, target 4; start; 4 tokens spaced 2 cycles apart. Expected: fu_clr_o low from cycle 2, done_o pulse after the 4th token, status 0, token_count_o=4.
- Target 10, timeout 3, no tokens. Expected: done_o in cycle 5, status 1, token_count_o=0.
- Timeout 3 with a token arriving exactly on the expiry cycle. Expected: no timeout; the run continues and the stall counter restarts.
- abort_i and the final token in the same cycle. Expected: status 2, and token_count_o includes that token.
- Config writes during RUN. Expected: fu_fork_mask_o and the other config outputs unchanged. Then target 0. Expected: done_o in cycle 3, status 0.
